// File: rtl/mp_pkg.sv
// Shared definitions for the 2x2 max-pooling engine: FSM encoding,
// read latency and default map geometry / RAM placement.
package mp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_RD3  = 3'd4,
    ST_CMP  = 3'd5,
    ST_WR   = 3'd6,
    ST_DONE = 3'd7
  } mp_state_e;

  localparam int          RD_LAT       = 1;
  localparam int          DEF_IN_W     = 28;
  localparam int          DEF_IN_H     = 28;
  localparam int          DEF_CH       = 4;
  localparam logic [15:0] DEF_IN_BASE  = 16'h0000;
  localparam logic [15:0] DEF_OUT_BASE = 16'h1000;

endpackage

// File: rtl/max_pool_2x2_if.sv
// Single-port-pair RAM bus used by the pooling engine: one read port with
// one-cycle latency and one write port with a separate write strobe.
interface max_pool_2x2_if;

  logic [15:0] ram_addr_r;
  logic        ram_en_r;
  logic [7:0]  ram_data_r;
  logic [15:0] ram_addr_w;
  logic [7:0]  ram_data_w;
  logic        ram_en_w;
  logic        ram_wea;

  modport master (
    output ram_addr_r, ram_en_r, ram_addr_w, ram_data_w, ram_en_w, ram_wea,
    input  ram_data_r
  );

  modport slave (
    input  ram_addr_r, ram_en_r, ram_addr_w, ram_data_w, ram_en_w, ram_wea,
    output ram_data_r
  );

endinterface

// File: rtl/mp_addr_gen.sv
// Window counters (channel, pooled row, pooled column) and the read/write
// address arithmetic for the 2x2 pooling engine.
module mp_addr_gen
  import mp_pkg::*;
#(
  parameter int          IN_W     = DEF_IN_W,
  parameter int          IN_H     = DEF_IN_H,
  parameter int          CH       = DEF_CH,
  parameter logic [15:0] IN_BASE  = DEF_IN_BASE,
  parameter logic [15:0] OUT_BASE = DEF_OUT_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        adv_i,
  input  logic [1:0]  sel_i,
  output logic [15:0] rd_addr_o,
  output logic [15:0] wr_addr_o,
  output logic        last_o
);

  localparam int          PW        = IN_W / 2;
  localparam int          PH        = IN_H / 2;
  localparam logic [15:0] ROW_W     = 16'(IN_W);
  localparam logic [15:0] PLANE_IN  = 16'(IN_W * IN_H);
  localparam logic [15:0] PLANE_OUT = 16'(PH * PW);
  localparam logic [15:0] PW16      = 16'(PW);
  localparam logic [15:0] LAST_C    = 16'(CH - 1);
  localparam logic [15:0] LAST_PR   = 16'(PH - 1);
  localparam logic [15:0] LAST_PX   = 16'(PW - 1);

  logic [15:0] c_q, c_d;
  logic [15:0] pr_q, pr_d;
  logic [15:0] px_q, px_d;
  logic [15:0] row_rd, col_rd;

  assign last_o = (c_q == LAST_C) && (pr_q == LAST_PR) && (px_q == LAST_PX);

  // px wraps into pr, pr wraps into c; the last window wraps everything to 0
  always_comb begin
    c_d  = c_q;
    pr_d = pr_q;
    px_d = px_q;
    if (clr_i) begin
      c_d  = '0;
      pr_d = '0;
      px_d = '0;
    end else if (adv_i) begin
      if (px_q == LAST_PX) begin
        px_d = '0;
        if (pr_q == LAST_PR) begin
          pr_d = '0;
          c_d  = (c_q == LAST_C) ? 16'd0 : c_q + 16'd1;
        end else begin
          pr_d = pr_q + 16'd1;
        end
      end else begin
        px_d = px_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q  <= '0;
      pr_q <= '0;
      px_q <= '0;
    end else begin
      c_q  <= c_d;
      pr_q <= pr_d;
      px_q <= px_d;
    end
  end

  // sel bit 1 picks the lower row of the window, bit 0 the right column
  assign row_rd = {pr_q[14:0], 1'b0} + {15'd0, sel_i[1]};
  assign col_rd = {px_q[14:0], 1'b0} + {15'd0, sel_i[0]};

  assign rd_addr_o = IN_BASE + c_q * PLANE_IN + row_rd * ROW_W + col_rd;
  assign wr_addr_o = OUT_BASE + c_q * PLANE_OUT + pr_q * PW16 + px_q;

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max pooling over a channel-major 8-bit feature map held in
// RAM; one window is read, reduced and written back every 6 cycles.
module max_pool_2x2
  import mp_pkg::*;
#(
  parameter int          IN_W     = DEF_IN_W,
  parameter int          IN_H     = DEF_IN_H,
  parameter int          CH       = DEF_CH,
  parameter logic [15:0] IN_BASE  = DEF_IN_BASE,
  parameter logic [15:0] OUT_BASE = DEF_OUT_BASE
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  max_pool_2x2_if.master ram,
  output logic           busy,
  output logic           done
);

  localparam longint IN_END  = longint'(IN_BASE) + longint'(CH) * IN_H * IN_W - 1;
  localparam longint OUT_END = longint'(OUT_BASE) + longint'(CH) * (IN_H / 2) * (IN_W / 2) - 1;

  if (IN_W < 2 || IN_H < 2 || CH < 1) begin : g_bad_dims
    $error("max_pool_2x2: map must be at least 2x2 with one channel");
  end
  if (IN_END > 64'hFFFF || OUT_END > 64'hFFFF) begin : g_bad_addr
    $error("max_pool_2x2: input or output map exceeds the 16-bit address space");
  end
  if (RD_LAT != 1) begin : g_bad_lat
    $error("max_pool_2x2: schedule assumes a one-cycle RAM read latency");
  end

  mp_state_e   state_q, state_d;
  logic [7:0]  max_q, max_d;
  logic [15:0] addr_r_q, addr_r_d;
  logic [15:0] addr_w_q, addr_w_d;
  logic [7:0]  data_w_q, data_w_d;
  logic        rd_phase, wr_phase;
  logic [1:0]  sel;
  logic [15:0] rd_addr, wr_addr;
  logic        last_win;

  mp_addr_gen #(
    .IN_W     (IN_W),
    .IN_H     (IN_H),
    .CH       (CH),
    .IN_BASE  (IN_BASE),
    .OUT_BASE (OUT_BASE)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     ((state_q == ST_IDLE) && start),
    .adv_i     (wr_phase),
    .sel_i     (sel),
    .rd_addr_o (rd_addr),
    .wr_addr_o (wr_addr),
    .last_o    (last_win)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RD0;
      ST_RD0:  state_d = ST_RD1;
      ST_RD1:  state_d = ST_RD2;
      ST_RD2:  state_d = ST_RD3;
      ST_RD3:  state_d = ST_CMP;
      ST_CMP:  state_d = ST_WR;
      ST_WR:   state_d = last_win ? ST_DONE : ST_RD0;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel = 2'd0;
    case (state_q)
      ST_RD1:  sel = 2'd1;
      ST_RD2:  sel = 2'd2;
      ST_RD3:  sel = 2'd3;
      default: sel = 2'd0;
    endcase
  end

  assign rd_phase = (state_q == ST_RD0) || (state_q == ST_RD1) ||
                    (state_q == ST_RD2) || (state_q == ST_RD3);
  assign wr_phase = (state_q == ST_WR);

  // Read data lags the enable by one cycle, so pixel k lands in the state after RDk
  always_comb begin
    max_d = max_q;
    case (state_q)
      ST_RD1: max_d = ram.ram_data_r;
      ST_RD2, ST_RD3, ST_CMP: if (ram.ram_data_r > max_q) max_d = ram.ram_data_r;
      default: max_d = max_q;
    endcase
  end

  assign addr_r_d = rd_phase ? rd_addr : addr_r_q;
  assign addr_w_d = wr_phase ? wr_addr : addr_w_q;
  assign data_w_d = wr_phase ? max_q   : data_w_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      max_q    <= '0;
      addr_r_q <= '0;
      addr_w_q <= '0;
      data_w_q <= '0;
    end else begin
      state_q  <= state_d;
      max_q    <= max_d;
      addr_r_q <= addr_r_d;
      addr_w_q <= addr_w_d;
      data_w_q <= data_w_d;
    end
  end

  assign ram.ram_en_r   = rd_phase;
  assign ram.ram_addr_r = addr_r_d;
  assign ram.ram_en_w   = wr_phase;
  assign ram.ram_wea    = wr_phase;
  assign ram.ram_addr_w = addr_w_d;
  assign ram.ram_data_w = data_w_d;

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2: a 4x4x1 instance and a 5x5x2 instance
// share one behavioural RAM; monitors pop expected writes/reads on each strobe.
module tb_max_pool_2x2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, busy_b, done_b;

  max_pool_2x2_if ifa();
  max_pool_2x2_if ifb();

  max_pool_2x2 #(.IN_W(4), .IN_H(4), .CH(1), .IN_BASE(16'h0000), .OUT_BASE(16'h1000)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .ram(ifa.master), .busy(busy_a), .done(done_a));

  max_pool_2x2 #(.IN_W(5), .IN_H(5), .CH(2), .IN_BASE(16'h0000), .OUT_BASE(16'h1000)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .ram(ifb.master), .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  always @(posedge clk) if (ifa.ram_en_r) ifa.ram_data_r <= mem[ifa.ram_addr_r[7:0]];
  always @(posedge clk) if (ifb.ram_en_r) ifb.ram_data_r <= mem[ifb.ram_addr_r[7:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t         exp_wa[$];
  wr_t         exp_wb[$];
  logic [15:0] exp_ra[$];
  int          done_cnt_a = 0, done_cnt_b = 0, reads_b = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input longint act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  // Monitor for the 4x4x1 instance: write/read scoreboards plus protocol rules
  logic done_prev_a = 1'b0, busy_prev_a = 1'b0, rst_prev_a = 1'b0;
  always @(negedge clk) begin : mon_a
    wr_t e;
    logic [15:0] ra;
    if (ifa.ram_en_w) begin
      chk("a_wea_with_en_w", ifa.ram_wea, 1);
      if (exp_wa.size() == 0) fail_now("a_extra_write", ifa.ram_addr_w);
      else begin
        e = exp_wa.pop_front();
        chk("a_wr_addr", ifa.ram_addr_w, e.a);
        chk("a_wr_data", ifa.ram_data_w, e.d);
      end
    end else if (ifa.ram_wea) fail_now("a_wea_without_en_w", ifa.ram_wea);
    if (ifa.ram_en_r) begin
      if (exp_ra.size() == 0) fail_now("a_extra_read", ifa.ram_addr_r);
      else begin
        ra = exp_ra.pop_front();
        chk("a_rd_addr", ifa.ram_addr_r, ra);
      end
    end
    if (ifa.ram_en_r || ifa.ram_en_w) chk("a_en_exclusive", ifa.ram_en_r & ifa.ram_en_w, 0);
    if (done_a) begin
      done_cnt_a++;
      chk("a_done_width", done_prev_a, 0);
      chk("a_busy_during_done", busy_a, 1);
    end
    if (rst_n && rst_prev_a && busy_prev_a && !busy_a) chk("a_busy_falls_with_done", done_prev_a, 1);
    done_prev_a = done_a;
    busy_prev_a = busy_a;
    rst_prev_a  = rst_n;
  end

  // Monitor for the 5x5x2 instance: row 4 / column 4 must never be addressed
  logic done_prev_b = 1'b0, busy_prev_b = 1'b0, rst_prev_b = 1'b0;
  always @(negedge clk) begin : mon_b
    wr_t e;
    int off;
    if (ifb.ram_en_w) begin
      chk("b_wea_with_en_w", ifb.ram_wea, 1);
      if (exp_wb.size() == 0) fail_now("b_extra_write", ifb.ram_addr_w);
      else begin
        e = exp_wb.pop_front();
        chk("b_wr_addr", ifb.ram_addr_w, e.a);
        chk("b_wr_data", ifb.ram_data_w, e.d);
      end
    end else if (ifb.ram_wea) fail_now("b_wea_without_en_w", ifb.ram_wea);
    if (ifb.ram_en_r) begin
      reads_b++;
      off = int'(ifb.ram_addr_r);
      chk("b_rd_in_pooled_area", (off < 50 && ((off % 25) / 5) != 4 && (off % 5) != 4) ? 1 : 0, 1);
    end
    if (ifb.ram_en_r || ifb.ram_en_w) chk("b_en_exclusive", ifb.ram_en_r & ifb.ram_en_w, 0);
    if (done_b) begin
      done_cnt_b++;
      chk("b_done_width", done_prev_b, 0);
    end
    if (rst_n && rst_prev_b && busy_prev_b && !busy_b) chk("b_busy_falls_with_done", done_prev_b, 1);
    done_prev_b = done_b;
    busy_prev_b = busy_b;
    rst_prev_b  = rst_n;
  end

  task automatic push_reads_a(input int nwin);
    for (int w = 0; w < nwin; w++) begin
      logic [15:0] base;
      base = 16'((w / 2) * 8 + (w % 2) * 2);
      exp_ra.push_back(base);
      exp_ra.push_back(base + 16'd1);
      exp_ra.push_back(base + 16'd4);
      exp_ra.push_back(base + 16'd5);
    end
  endtask

  task automatic push_wr_a(input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] m2, input logic [7:0] m3);
    exp_wa.push_back({16'h1000, m0});
    exp_wa.push_back({16'h1001, m1});
    exp_wa.push_back({16'h1002, m2});
    exp_wa.push_back({16'h1003, m3});
  endtask

  // Pulse start, optionally re-pulse it mid-pass, then wait (bounded) for done
  task automatic run(input int d, input int exp_lat, input int repulse_at);
    int  sc, lat;
    bit  got;
    @(negedge clk);
    if (d == 0) start_a = 1'b1; else start_b = 1'b1;
    sc = cyc;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    if (repulse_at > 0) begin
      while (cyc < sc + repulse_at) @(negedge clk);
      if (d == 0) start_a = 1'b1; else start_b = 1'b1;
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
    end
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      if ((d == 0) ? done_a : done_b) begin
        got = 1'b1;
        lat = cyc - sc;
      end else @(negedge clk);
    end
    if (!got) fail_now("done_timeout", cyc - sc);
    else chk((d == 0) ? "a_done_latency" : "b_done_latency", lat, exp_lat);
    @(negedge clk);
    if (d == 0) begin
      chk("a_writes_outstanding", exp_wa.size(), 0);
      chk("a_reads_outstanding", exp_ra.size(), 0);
    end else begin
      chk("b_writes_outstanding", exp_wb.size(), 0);
    end
  endtask

  logic [7:0] bv   [8][4];
  logic [7:0] bmax [8];

  initial begin
    int sc, snap, rsnap, k;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_a_en", {ifa.ram_en_r, ifa.ram_en_w, ifa.ram_wea}, 0);
    chk("rst_a_addr_r", ifa.ram_addr_r, 0);
    chk("rst_a_addr_w", ifa.ram_addr_w, 0);
    chk("rst_a_data_w", ifa.ram_data_w, 0);
    chk("rst_a_busy_done", {busy_a, done_a}, 0);
    chk("rst_b_outs", {ifb.ram_en_r, ifb.ram_en_w, ifb.ram_wea, busy_b, done_b}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 4x4x1 ramp 0..15
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    push_reads_a(4);
    push_wr_a(8'd5, 8'd7, 8'd13, 8'd15);
    run(0, 25, 0);

    // Same map, start re-pulsed in window 1 (cycle 8)
    push_reads_a(4);
    push_wr_a(8'd5, 8'd7, 8'd13, 8'd15);
    run(0, 25, 8);

    // All pixels equal
    for (int i = 0; i < 16; i++) mem[i] = 8'hAA;
    push_reads_a(4);
    push_wr_a(8'hAA, 8'hAA, 8'hAA, 8'hAA);
    run(0, 25, 0);

    // One 0xFF per window, each at a different window position
    for (int i = 0; i < 16; i++) mem[i] = 8'h10;
    mem[0] = 8'hFF; mem[3] = 8'hFF; mem[12] = 8'hFF; mem[15] = 8'hFF;
    push_reads_a(4);
    push_wr_a(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run(0, 25, 0);

    // 5x5x2: the ignored row/column hold 0xFE so a stray read would win
    for (int i = 0; i < 50; i++) mem[i] = 8'hFE;
    bv[0] = '{8'h7F, 8'h80, 8'h01, 8'h02}; bmax[0] = 8'h80;
    bv[1] = '{8'h10, 8'h20, 8'h30, 8'h40}; bmax[1] = 8'h40;
    bv[2] = '{8'h90, 8'h10, 8'h20, 8'h30}; bmax[2] = 8'h90;
    bv[3] = '{8'h05, 8'h05, 8'h06, 8'h05}; bmax[3] = 8'h06;
    bv[4] = '{8'h33, 8'hC0, 8'h11, 8'hC0}; bmax[4] = 8'hC0;
    bv[5] = '{8'h00, 8'h00, 8'h00, 8'h00}; bmax[5] = 8'h00;
    bv[6] = '{8'h01, 8'hFF, 8'h02, 8'h03}; bmax[6] = 8'hFF;
    bv[7] = '{8'h44, 8'h43, 8'h42, 8'h41}; bmax[7] = 8'h44;
    for (int w = 0; w < 8; w++) begin
      int base;
      base = (w / 4) * 25 + ((w / 2) % 2) * 10 + (w % 2) * 2;
      mem[base]     = bv[w][0];
      mem[base + 1] = bv[w][1];
      mem[base + 5] = bv[w][2];
      mem[base + 6] = bv[w][3];
      exp_wb.push_back({16'h1000 + 16'(w), bmax[w]});
    end
    rsnap = reads_b;
    run(1, 49, 0);
    chk("b_read_count", reads_b - rsnap, 32);

    // Reset during the write of window 2, then a clean rerun
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    push_reads_a(3);
    exp_wa.push_back({16'h1000, 8'd5});
    exp_wa.push_back({16'h1001, 8'd7});
    snap = done_cnt_a;
    @(negedge clk);
    start_a = 1'b1;
    sc = cyc;
    @(negedge clk);
    start_a = 1'b0;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (cyc != sc + 18 && k < 100);
    chk("a_in_wr_of_window2", ifa.ram_en_w, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_a_en", {ifa.ram_en_r, ifa.ram_en_w, ifa.ram_wea}, 0);
    chk("abort_a_addr_w", ifa.ram_addr_w, 0);
    chk("abort_a_data_w", ifa.ram_data_w, 0);
    chk("abort_a_addr_r", ifa.ram_addr_r, 0);
    chk("abort_a_busy_done", {busy_a, done_a}, 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt_a - snap, 0);
    chk("abort_writes_consumed", exp_wa.size(), 0);
    chk("abort_reads_consumed", exp_ra.size(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push_reads_a(4);
    push_wr_a(8'd5, 8'd7, 8'd13, 8'd15);
    run(0, 25, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/max_pool_2x2.md
MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 Parameters (name, default, meaning): IN_W 28 input map width; IN_H 28 input map height; CH 4 channel count; IN_BASE 16'h0000 input map RAM base; OUT_BASE 16'h1000 pooled map RAM base.
REQ-002 Ports (name direction width meaning):
- clk in 1 clock, rising edge.
- rst_n in 1 reset, asynchronous, active-low.
- start in 1 one-cycle pulse that launches a pooling pass.
- ram_addr_r out 16 read address.
- ram_en_r out 1 read enable.
- ram_data_r in 8 read data, unsigned, valid exactly 1 cycle after ram_en_r.
- ram_addr_w out 16 write address.
- ram_data_w out 8 write data.
- ram_en_w out 1 write-port enable.
- ram_wea out 1 write strobe.
- busy out 1 high from the cycle after start acceptance until done.
- done out 1 one-cycle completion pulse, wired as end_MP1.

Function
REQ-003 Input layout SHALL be channel-major, row-major: addr = IN_BASE + c*IN_H*IN_W + r*IN_W + x.
REQ-004 Output layout SHALL be addr = OUT_BASE + c*PH*PW + pr*PW + px, where PH = floor(IN_H/2) and PW = floor(IN_W/2).
REQ-005 For odd dimensions, the last input row or column SHALL be ignored.
REQ-006 FSM states SHALL be IDLE, RD0, RD1, RD2, RD3, CMP, WR, DONE.
REQ-007 IDLE SHALL go to RD0 on start; any other state SHALL ignore start.
REQ-008 RD0..RD3 SHALL each assert ram_en_r for one cycle, at window pixels (2pr,2px), (2pr,2px+1), (2pr+1,2px), (2pr+1,2px+1), in that order.
REQ-009 The running max SHALL load the data arriving in RD1 and compare against data arriving in RD2, RD3 and CMP, using unsigned compare; ties keep the held value.
REQ-010 WR SHALL assert ram_en_w=1 and ram_wea=1 for one cycle, with the max on ram_data_w and the REQ-004 address on ram_addr_w.
REQ-011 After WR, counters SHALL advance in this order: px, then pr, then c. The last window SHALL go to DONE; otherwise the FSM returns to RD0.
REQ-012 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-013 Each window SHALL take exactly 6 cycles. Done SHALL appear 6*CH*PH*PW + 1 cycles after the start cycle.
REQ-014 Read and write enables SHALL never be high in the same cycle.
REQ-015 Outside RD states, ram_en_r=0. Outside WR, ram_en_w=0 and ram_wea=0. Addresses and data hold their last values.
REQ-016 Address arithmetic SHALL be 16-bit; parameters SHALL be chosen so no address exceeds 16'hFFFF (elaboration-time check).

Reset
REQ-017 rst_n low SHALL force IDLE, zero all counters and the max register, and drive every output to 0.
REQ-018 Reset mid-pass SHALL abort with no done pulse; the next start SHALL run a full pass from window 0.

Structure
REQ-019 Package mp_pkg SHALL hold the state enum, RD_LAT=1, and the default dimension/base constants.
REQ-020 Sub-module mp_addr_gen SHALL hold the c/pr/px counters and produce read/write addresses; the FSM and max register stay in max_pool_2x2.

Verification
REQ-021 4x4x1 map with values 0..15 row-major: writes at OUT_BASE+0..3 are 5, 7, 13, 15; done occurs at cycle 25.
REQ-022 Map with all pixels 8'hAA: every output is 8'hAA (tie handling); with a single 8'hFF in each window, every output is 8'hFF.
REQ-023 5x5x2 map: 8 writes occur; row 4 and column 4 are never read (address monitor).
REQ-024 start re-pulsed during window 1: no restart occurs, and the write sequence and done timing are unchanged.
REQ-025 rst_n asserted during WR of window 2: outputs are 0 at once, no done pulse; a following start rewrites from OUT_BASE+0.
REQ-026 Continuous monitor: ram_en_r and ram_en_w are never both high; done width is 1 cycle; busy falls with done.
